// File: rtl/rfid_pkg.sv
// Shared constants, enums and the ASCII-hex decoder for the RDM6300-style frame parser.
// STX/ETX framing bytes and nibble counts of the data and checksum fields.
package rfid_pkg;

    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h03;

    localparam int DATA_NIBBLES = 10;
    localparam int CSUM_NIBBLES = 2;

    typedef enum logic [1:0] {
        ERR_BAD_CHAR = 2'd0,
        ERR_CSUM     = 2'd1,
        ERR_NO_ETX   = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CSUM = 2'd2,
        ST_ETX  = 2'd3
    } parser_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } hex_nib_t;

    // Upper- and lowercase A-F both map to 10..15 via the low ASCII nibble plus 9.
    function automatic hex_nib_t hex_decode(input logic [7:0] ch);
        hex_nib_t r;
        r.valid  = 1'b1;
        r.nibble = 4'h0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            r.nibble = ch[3:0];
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            r.nibble = ch[3:0] + 4'd9;
        end else begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/rfid_frame_parser.sv
// Assembles STX + 10 hex data chars + 2 hex checksum chars + ETX frames from a UART byte
// stream; emits a 40-bit tag ID on accept or an error pulse/code on rejection.
module rfid_frame_parser
    import rfid_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 50000
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Tag_DV,
    output logic [39:0] o_Tag_ID,
    output logic        o_Tag_New,
    output logic        o_Frame_Err,
    output logic [1:0]  o_Err_Code
);

    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_DATA = ST_DATA;
    localparam logic [1:0] S_CSUM = ST_CSUM;
    localparam logic [1:0] S_ETX  = ST_ETX;

    localparam logic [3:0] DATA_LAST = 4'(DATA_NIBBLES - 1);
    localparam logic [3:0] CSUM_LAST = 4'(CSUM_NIBBLES - 1);

    logic [1:0]    state;
    logic [3:0]    nib_cnt;
    logic [39:0]   data_sr;
    logic [7:0]    csum_sr;
    logic [TW-1:0] tmo_cnt;
    logic [39:0]   last_id;
    logic          seen_first;

    hex_nib_t      hex;
    logic [7:0]    data_xor;
    logic          tmo_hit;
    logic          is_stx;

    assign hex      = hex_decode(i_Rx_Byte);
    assign is_stx   = (i_Rx_Byte == STX);
    assign data_xor = data_sr[39:32] ^ data_sr[31:24] ^ data_sr[23:16]
                    ^ data_sr[15:8] ^ data_sr[7:0];
    // A byte arriving on the terminal count cycle wins over the timeout.
    assign tmo_hit  = (state != S_IDLE) && !i_Rx_DV && (tmo_cnt == TMO_LAST);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            nib_cnt     <= 4'd0;
            data_sr     <= 40'd0;
            csum_sr     <= 8'd0;
            tmo_cnt     <= '0;
            last_id     <= 40'd0;
            seen_first  <= 1'b0;
            o_Tag_DV    <= 1'b0;
            o_Tag_ID    <= 40'd0;
            o_Tag_New   <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Err_Code  <= 2'd0;
        end else begin
            o_Tag_DV    <= 1'b0;
            o_Tag_New   <= 1'b0;
            o_Frame_Err <= 1'b0;

            if (state == S_IDLE || i_Rx_DV || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (tmo_hit) begin
                o_Frame_Err <= 1'b1;
                o_Err_Code  <= ERR_TIMEOUT;
                state       <= S_IDLE;
            end else if (i_Rx_DV) begin
                case (state)
                    S_IDLE: begin
                        if (is_stx) begin
                            state   <= S_DATA;
                            nib_cnt <= 4'd0;
                        end
                    end

                    S_DATA: begin
                        if (is_stx) begin
                            o_Frame_Err <= 1'b1;
                            o_Err_Code  <= ERR_BAD_CHAR;
                            nib_cnt     <= 4'd0;
                        end else if (hex.valid) begin
                            data_sr <= {data_sr[35:0], hex.nibble};
                            if (nib_cnt == DATA_LAST) begin
                                state   <= S_CSUM;
                                nib_cnt <= 4'd0;
                            end else begin
                                nib_cnt <= nib_cnt + 4'd1;
                            end
                        end else begin
                            o_Frame_Err <= 1'b1;
                            o_Err_Code  <= ERR_BAD_CHAR;
                            state       <= S_IDLE;
                        end
                    end

                    S_CSUM: begin
                        if (is_stx) begin
                            o_Frame_Err <= 1'b1;
                            o_Err_Code  <= ERR_BAD_CHAR;
                            state       <= S_DATA;
                            nib_cnt     <= 4'd0;
                        end else if (hex.valid) begin
                            csum_sr <= {csum_sr[3:0], hex.nibble};
                            if (nib_cnt == CSUM_LAST) begin
                                state   <= S_ETX;
                                nib_cnt <= 4'd0;
                            end else begin
                                nib_cnt <= nib_cnt + 4'd1;
                            end
                        end else begin
                            o_Frame_Err <= 1'b1;
                            o_Err_Code  <= ERR_BAD_CHAR;
                            state       <= S_IDLE;
                        end
                    end

                    S_ETX: begin
                        if (i_Rx_Byte == ETX) begin
                            if (csum_sr == data_xor) begin
                                // New-ID flag compares against the previous accept, then the history updates.
                                o_Tag_DV   <= 1'b1;
                                o_Tag_ID   <= data_sr;
                                o_Tag_New  <= !seen_first || (data_sr != last_id);
                                last_id    <= data_sr;
                                seen_first <= 1'b1;
                            end else begin
                                o_Frame_Err <= 1'b1;
                                o_Err_Code  <= ERR_CSUM;
                            end
                            state <= S_IDLE;
                        end else begin
                            o_Frame_Err <= 1'b1;
                            o_Err_Code  <= ERR_NO_ETX;
                            nib_cnt     <= 4'd0;
                            state       <= is_stx ? S_DATA : S_IDLE;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
